voq_pick: RTL and testbench
===========================

Name: voq_pick

Overview:
- Round-robin VOQ selector for one ingress port, used by the crossbar scheduler (sched) once per ingress per assignment step.
- Given the ingress's VOQ-empty flags, the global egress-already-picked mask and a round-robin start index, it returns the first eligible VOQ/egress at or after the start index, with wrap-around.
- The primary result is combinational, so sched can consume it in the same cycle.
- A registered copy of the result is provided for pipelined or debug use.

Parameters:
- NUM_VOQ, 4, number of VOQs per ingress, equal to the number of egress ports; must be a power of two, at least 2.
- IDX_W, $clog2(NUM_VOQ) (2 at default), width of VOQ index fields; derived, not overridden.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start_voq_num  input  IDX_W  round-robin start index; highest-priority VOQ this cycle
- voq_empty  input  NUM_VOQ  bit i=1: this ingress's VOQ i holds no packet
- voq_picked  input  NUM_VOQ  bit i=1: egress i already granted this round (busy or picked by another ingress)
- no_available_voq  output  1  combinational; 1 when no VOQ is eligible
- voq_to_pick  output  IDX_W  combinational; selected VOQ/egress index
- pick_valid_q  output  1  registered ~no_available_voq
- voq_to_pick_q  output  IDX_W  registered voq_to_pick

Behaviour:
- Eligibility: VOQ i is eligible iff voq_empty[i]==0 and voq_picked[i]==0.
- Search order is start_voq_num, start_voq_num+1, ..., start_voq_num+NUM_VOQ-1. Each index wraps modulo NUM_VOQ, using natural IDX_W-bit overflow.
- voq_to_pick is the first eligible index in search order. no_available_voq=0 when at least one VOQ is eligible.
- If no VOQ is eligible: no_available_voq=1 and voq_to_pick=start_voq_num. Consumers must ignore voq_to_pick in this case.
- The combinational path has no dependency on clk or reset. Outputs settle in the same cycle as the inputs, with zero latency.
- Registered path, on each rising clk:
  - pick_valid_q <= ~no_available_voq
  - voq_to_pick_q <= voq_to_pick
- Reset: while reset=1, pick_valid_q=0 and voq_to_pick_q=0, asynchronously. The combinational outputs keep tracking their inputs during reset.
- Boundary conditions:
  - voq_empty all 1s -> none available.
  - voq_picked all 1s -> none available.
  - A VOQ that is both non-empty and picked is skipped.
  - start_voq_num = NUM_VOQ-1 wraps to index 0 next.
  - Exactly one eligible VOQ is selected regardless of start_voq_num.
- The block holds no round-robin state. Advancing start_voq_num is the caller's job; sched increments it after a successful pick.
- X/latch-free: every output is assigned on all paths; no inferred latches.

Decomposition:
- Shared package: NUM_VOQ default and the voq_idx_t typedef (logic [IDX_W-1:0]), shared with sched and the ingress modules.
- Implementation structure:
  - Compute an eligible mask, rotate it right by start_voq_num, and pass it through a fixed-priority (lowest-index-first) encoder.
  - Add start_voq_num back to the encoder result modulo NUM_VOQ.
  - Implement the rotate-and-encode as one sub-module, rr_prio_enc, parameterized by width.
- Only the output registers live in voq_pick.

Test Plan:
- start=0, empty=4'b1111, picked=4'b0000 -> no_available_voq=1, voq_to_pick=0.
- start=0, empty=4'b0000, picked=4'b0000 -> no_available_voq=0, voq_to_pick=0; with start=2 -> voq_to_pick=2.
- start=3, empty=4'b0110 (VOQ 0 and 3 non-empty), picked=4'b1000 -> VOQ 3 is skipped as picked and the search wraps: voq_to_pick=0, no_available_voq=0.
- start=1, empty=4'b0000, picked=4'b1110 -> voq_to_pick=0 (wrap). Then picked=4'b1111 -> no_available_voq=1, voq_to_pick=1.
- Exhaustive sweep, with a reference model, over all 4x16x16 input combinations: voq_to_pick equals the first eligible index in search order, and no_available_voq equals (eligible mask == 0).
- Registered path:
  - Assert reset mid-run -> pick_valid_q and voq_to_pick_q go to 0 immediately, without waiting for a clock edge.
  - After deassert, apply start=2, empty=4'b1011, picked=0 -> one cycle later pick_valid_q=1 and voq_to_pick_q=2.

Source files
------------

// File: rtl/voq_pick_pkg.sv
// rtl/voq_pick_pkg.sv - shared VOQ sizing and index type for sched, ingress and voq_pick
package voq_pick_pkg;

  localparam int NUM_VOQ_DEFAULT = 4;
  localparam int IDX_W_DEFAULT   = $clog2(NUM_VOQ_DEFAULT);

  typedef logic [IDX_W_DEFAULT-1:0] voq_idx_t;

endpackage

// File: rtl/voq_pick_rr_prio_enc.sv
// rtl/voq_pick_rr_prio_enc.sv - rotate-right by start, lowest-index-first encode, add start back
module rr_prio_enc #(
  parameter int WIDTH = 4,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*WIDTH-1:0] req_dbl;
  logic [2*WIDTH-1:0] req_shifted;
  logic [WIDTH-1:0]   req_rot;
  logic [IDX_W-1:0]   enc;

  // Shifting a doubled copy gives a rotate without a variable-width left shift.
  assign req_dbl     = {req, req};
  assign req_shifted = req_dbl >> start;
  assign req_rot     = req_shifted[WIDTH-1:0];

  always_comb begin
    enc = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_rot[i]) enc = IDX_W'(i);
    end
  end

  assign found = |req;
  // Power-of-two width makes natural overflow the modulo; enc=0 leaves idx=start when nothing is found.
  assign idx   = start + enc;

endmodule

// File: rtl/voq_pick.sv
// rtl/voq_pick.sv - round-robin VOQ selector for one ingress, combinational pick plus registered copy
module voq_pick
  import voq_pick_pkg::*;
#(
  parameter int NUM_VOQ = NUM_VOQ_DEFAULT,
  localparam int IDX_W = $clog2(NUM_VOQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IDX_W-1:0]   start_voq_num,
  input  logic [NUM_VOQ-1:0] voq_empty,
  input  logic [NUM_VOQ-1:0] voq_picked,
  output logic               no_available_voq,
  output logic [IDX_W-1:0]   voq_to_pick,
  output logic               pick_valid_q,
  output logic [IDX_W-1:0]   voq_to_pick_q
);

  logic [NUM_VOQ-1:0] eligible;
  logic               found;
  logic               pick_valid_d;
  logic [IDX_W-1:0]   voq_to_pick_d;

  assign eligible = ~voq_empty & ~voq_picked;

  rr_prio_enc #(.WIDTH(NUM_VOQ)) u_enc (
    .req   (eligible),
    .start (start_voq_num),
    .found (found),
    .idx   (voq_to_pick)
  );

  assign no_available_voq = ~found;
  assign pick_valid_d     = found;
  assign voq_to_pick_d    = voq_to_pick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pick_valid_q  <= 1'b0;
      voq_to_pick_q <= '0;
    end else begin
      pick_valid_q  <= pick_valid_d;
      voq_to_pick_q <= voq_to_pick_d;
    end
  end

endmodule

// File: tb/tb_voq_pick.sv
// tb/tb_voq_pick.sv - randomized and directed checks of voq_pick against a search-order model
module tb_voq_pick;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] start_voq_num = '0;
  logic [N-1:0] voq_empty = '1;
  logic [N-1:0] voq_picked = '0;
  logic         no_available_voq;
  logic [W-1:0] voq_to_pick;
  logic         pick_valid_q;
  logic [W-1:0] voq_to_pick_q;

  int n_vec = 0;
  int n_bad = 0;

  voq_pick #(.NUM_VOQ(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_voq_num    (start_voq_num),
    .voq_empty        (voq_empty),
    .voq_picked       (voq_picked),
    .no_available_voq (no_available_voq),
    .voq_to_pick      (voq_to_pick),
    .pick_valid_q     (pick_valid_q),
    .voq_to_pick_q    (voq_to_pick_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Walk the search order literally: start, start+1, ... modulo N.
  function automatic void model(input int s, input int e, input int p,
                                output int none, output int pick);
    none = 1;
    pick = s;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (s + k) % N;
      if (((e >> j) & 1) == 0 && ((p >> j) & 1) == 0) begin
        none = 0;
        pick = j;
        break;
      end
    end
  endfunction

  int exp_none, exp_pick;

  task automatic apply(input int s, input int e, input int p, input string tag);
    @(negedge clk);
    start_voq_num = W'(s);
    voq_empty     = N'(e);
    voq_picked    = N'(p);
    #1;
    model(s, e, p, exp_none, exp_pick);
    check({tag, ".none"}, int'(no_available_voq), exp_none);
    check({tag, ".pick"}, int'(voq_to_pick), exp_pick);
  endtask

  task automatic check_reg(input string tag);
    @(posedge clk);
    #1;
    check({tag, ".valid_q"}, int'(pick_valid_q), 1 - exp_none);
    check({tag, ".pick_q"}, int'(voq_to_pick_q), exp_pick);
  endtask

  initial begin
    #1;
    check("rst.valid_q", int'(pick_valid_q), 0);
    check("rst.pick_q", int'(voq_to_pick_q), 0);
    apply(0, 4'b1111, 4'b0000, "rst_comb");
    check("rst_comb.const_none", int'(no_available_voq), 1);
    @(negedge clk);
    reset = 1'b0;

    apply(0, 4'b1111, 4'b0000, "all_empty");
    check("all_empty.const", int'(voq_to_pick), 0);
    apply(0, 4'b0000, 4'b0000, "all_full_s0");
    check("all_full_s0.const", int'(voq_to_pick), 0);
    apply(2, 4'b0000, 4'b0000, "all_full_s2");
    check("all_full_s2.const", int'(voq_to_pick), 2);
    apply(3, 4'b0110, 4'b1000, "skip_wrap");
    check("skip_wrap.const", int'(voq_to_pick), 0);
    apply(1, 4'b0000, 4'b1110, "picked_wrap");
    check("picked_wrap.const", int'(voq_to_pick), 0);
    apply(1, 4'b0000, 4'b1111, "all_picked");
    check("all_picked.const_none", int'(no_available_voq), 1);
    check("all_picked.const_pick", int'(voq_to_pick), 1);
    for (int s = 0; s < N; s++) apply(s, 4'b1101, 4'b0000, "single");

    for (int s = 0; s < N; s++)
      for (int e = 0; e < 16; e++)
        for (int p = 0; p < 16; p++)
          apply(s, e, p, "sweep");

    for (int i = 0; i < 300; i++) begin
      apply(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), "rand");
      check_reg("rand");
    end

    apply(1, 4'b0000, 4'b0001, "pre_rst");
    check_reg("pre_rst");
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst.valid_q", int'(pick_valid_q), 0);
    check("mid_rst.pick_q", int'(voq_to_pick_q), 0);
    check("mid_rst.comb", int'(voq_to_pick), 1);
    @(negedge clk);
    reset = 1'b0;
    apply(2, 4'b1011, 4'b0000, "post_rst");
    check_reg("post_rst");
    check("post_rst.const_valid", int'(pick_valid_q), 1);
    check("post_rst.const_pick", int'(voq_to_pick_q), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
